// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   seq_state_t : sequencer state encoding
//   cnt_width() : width of the shared cycle counter, sized for the largest
//                 phase duration so the counter never wraps
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } seq_state_t;

  // The counter only ever reaches (duration - 1), so $clog2(max) bits suffice.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit level signal.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output (2-cycle latency)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses PLL RESETB, waits for (synchronized) lock,
// requires a run of stable lock before releasing the output-domain reset,
// retries on timeout and gives up after MAX_RETRIES failed attempts.
//   clk         : reference clock
//   rst         : asynchronous active-high reset
//   pll_lock    : PLL LOCK, asynchronous to clk
//   restart     : one-cycle request to restart the sequence
//   pll_resetb  : PLL RESETB (active-low)
//   sys_reset   : reset for the PLL output clock domain (active-high)
//   locked      : high while running
//   fail        : high after the retry budget is exhausted
//   lock_lost   : one-cycle pulse when lock drops while running
//   retry_count : failed attempts since last run entry, restart or reset
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pll_lock,
  input  logic                               restart,
  output logic                               pll_resetb,
  output logic                               sys_reset,
  output logic                               locked,
  output logic                               fail,
  output logic                               lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

  localparam int unsigned CW = cnt_width(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RC_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] LT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SC_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] MR      = RW'(MAX_RETRIES);

  seq_state_t    state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic [RW-1:0] next_retry;
  logic          lost;
  logic          lock_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_HOLD;
      cnt         <= '0;
      retry_count <= '0;
    end else begin
      state       <= next_state;
      cnt         <= next_cnt;
      retry_count <= next_retry;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt + 1'b1;
    next_retry = retry_count;
    lost       = (state == ST_RUN) && !lock_s;

    case (state)
      ST_HOLD: begin
        if (cnt == RC_LAST) begin
          next_state = ST_WAIT_LOCK;
          next_cnt   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          next_state = ST_STABLE;
          next_cnt   = '0;
        end else if (cnt == LT_LAST) begin
          next_cnt = '0;
          if (retry_count < MR) next_retry = retry_count + 1'b1;
          next_state = (next_retry == MR) ? ST_FAIL : ST_HOLD;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          next_state = ST_WAIT_LOCK;
          next_cnt   = '0;
        end else if (cnt == SC_LAST) begin
          next_state = ST_RUN;
          next_cnt   = '0;
          next_retry = '0;
        end
      end
      ST_RUN: begin
        next_cnt = '0;
        if (!lock_s) next_state = ST_HOLD;
      end
      ST_FAIL: begin
        next_cnt = '0;
      end
      default: begin
        next_state = ST_HOLD;
        next_cnt   = '0;
      end
    endcase

    // restart overrides everything; lost is left alone so a same-cycle
    // lock loss in RUN is still reported
    if (restart) begin
      next_state = ST_HOLD;
      next_cnt   = '0;
      next_retry = '0;
    end
  end

  // Outputs are flopped from next_state so they change exactly with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pll_resetb <= 1'b0;
      sys_reset  <= 1'b1;
      locked     <= 1'b0;
      fail       <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      pll_resetb <= (next_state == ST_WAIT_LOCK) || (next_state == ST_STABLE) ||
                    (next_state == ST_RUN);
      sys_reset  <= (next_state != ST_RUN);
      locked     <= (next_state == ST_RUN);
      fail       <= (next_state == ST_FAIL);
      lock_lost  <= lost;
    end
  end

endmodule
